spi_reg_arb: RTL and testbench

SPI_REG_ARB -- requirements
Module: spi_reg_arb

---
 rtl/spi_reg_pkg.sv | 13 +
 rtl/rr_arb2.sv | 27 ++
 rtl/spi_reg_arb.sv | 118 +++++++++++
 tb/tb_spi_reg_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and arbiter state encoding for the SPI/core register bank.
package spi_reg_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned REG_W_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGntSpi  = 2'd1,
    StGntCore = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; SPI has priority out of reset.
module rr_arb2 (
  input  logic clk,
  input  logic nrst,
  input  logic req_spi,
  input  logic req_core,
  output logic gnt_spi,
  output logic gnt_core
);

  logic last_core_q;

  always_comb begin
    gnt_spi  = req_spi & (~req_core | last_core_q);
    gnt_core = req_core & (~req_spi | ~last_core_q);
  end

  // Starting as "core granted last" gives SPI the first tie.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_core_q <= 1'b1;
    end else if (gnt_spi | gnt_core) begin
      last_core_q <= gnt_core;
    end
  end

endmodule

// File: rtl/spi_reg_arb.sv
// Register bank shared by an unstallable SPI writer and a req/gnt core port.
// Optional macro SPI_REG_ARB_RO_TOP_EN makes the top address read-only from SPI.
module spi_reg_arb
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [ADDR_W-1:0]             spi_addr,
  input  logic [REG_W-1:0]              spi_wdata,
  input  logic                          spi_wvld,
  output logic [REG_W-1:0]              spi_rdata,
  input  logic                          core_req,
  input  logic                          core_we,
  input  logic [ADDR_W-1:0]             core_addr,
  input  logic [REG_W-1:0]              core_wdata,
  output logic                          core_gnt,
  output logic [REG_W-1:0]              core_rdata,
  output logic                          core_rvld,
  output logic                          spi_ovf,
  input  logic                          ovf_clr,
  output logic [(2**ADDR_W)*REG_W-1:0]  regs_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [REG_W-1:0]  bank_q [Depth];
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [REG_W-1:0]  pend_data_q, pend_data_d;
  logic              ovf_q, rvld_q;
  logic [REG_W-1:0]  rdata_q;
  arb_state_t        state_q, state_d;
  logic              ro_hit, drain, accept, drop;
  logic              gnt_spi, gnt_core, core_arb_req;

`ifdef SPI_REG_ARB_RO_TOP_EN
  localparam logic [ADDR_W-1:0] TopAddr = {ADDR_W{1'b1}};
  assign ro_hit = (spi_addr == TopAddr);
`else
  assign ro_hit = 1'b0;
`endif

  // Pending buffer: a draining entry frees the slot for a same-cycle capture.
  always_comb begin
    drain       = (state_q == StGntSpi);
    accept      = spi_wvld & ~ro_hit & (~pend_vld_q | drain);
    drop        = spi_wvld & ~ro_hit & pend_vld_q & ~drain;
    pend_vld_d  = accept | (pend_vld_q & ~drain);
    pend_addr_d = accept ? spi_addr : pend_addr_q;
    pend_data_d = accept ? spi_wdata : pend_data_q;
  end

  // A core request already being granted must not re-arbitrate.
  assign core_arb_req = core_req & (state_q != StGntCore);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .nrst     (nrst),
    .req_spi  (pend_vld_d),
    .req_core (core_arb_req),
    .gnt_spi  (gnt_spi),
    .gnt_core (gnt_core)
  );

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StIdle;
    if (gnt_spi)       state_d = StGntSpi;
    else if (gnt_core) state_d = StGntCore;
  end

  // A core request withdrawn before its grant cycle commits nothing.
  always_comb begin
    core_gnt = (state_q == StGntCore) & core_req;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < Depth; i++) bank_q[i] <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
      rvld_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      if (drain && pend_vld_q) begin
        bank_q[pend_addr_q] <= pend_data_q;
      end else if (core_gnt && core_we) begin
        bank_q[core_addr] <= core_wdata;
      end
      rvld_q <= core_gnt & ~core_we;
      if (core_gnt && !core_we) rdata_q <= bank_q[core_addr];
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign spi_rdata  = (pend_vld_q && pend_addr_q == spi_addr) ? pend_data_q : bank_q[spi_addr];
  assign core_rdata = rdata_q;
  assign core_rvld  = rvld_q;
  assign spi_ovf    = ovf_q;

  for (genvar n = 0; n < Depth; n++) begin : g_regs
    assign regs_o[n*REG_W +: REG_W] = bank_q[n];
  end

endmodule

// File: tb/tb_spi_reg_arb.sv
// Directed bench for spi_reg_arb; inputs change and outputs are sampled on negedge.
module tb_spi_reg_arb;

  localparam int unsigned AW = 3;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [AW-1:0] spi_addr = '0;
  logic [RW-1:0] spi_wdata = '0;
  logic          spi_wvld = 1'b0;
  logic [RW-1:0] spi_rdata;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [RW-1:0] core_wdata = '0;
  logic          core_gnt;
  logic [RW-1:0] core_rdata;
  logic          core_rvld;
  logic          spi_ovf;
  logic          ovf_clr = 1'b0;
  logic [(2**AW)*RW-1:0] regs_o;

  int n_cmp = 0;
  int n_err = 0;

  spi_reg_arb #(.ADDR_W(AW), .REG_W(RW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_wvld   (spi_wvld),
    .spi_rdata  (spi_rdata),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rdata (core_rdata),
    .core_rvld  (core_rvld),
    .spi_ovf    (spi_ovf),
    .ovf_clr    (ovf_clr),
    .regs_o     (regs_o)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] ent(input int n);
    return regs_o[n*RW +: RW];
  endfunction

  task automatic idle_inputs();
    spi_wvld = 1'b0; spi_addr = '0; spi_wdata = '0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ovf_clr = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (regs_o !== '0) begin n_err++; $display("FAIL reset_regs: got %h want 0", regs_o); end
    n_cmp++; if (spi_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", spi_ovf); end
    n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", core_gnt); end
    n_cmp++; if (core_rvld !== 1'b0) begin n_err++; $display("FAIL reset_rvld: got %b want 0", core_rvld); end
    n_cmp++; if (core_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", core_rdata); end
  endtask

  task automatic test_spi_write();
    apply_reset();
    spi_wvld = 1'b1; spi_addr = 3'd2; spi_wdata = 8'h5A;
    @(negedge clk);
    spi_wvld = 1'b0;
    @(negedge clk);
    n_cmp++; if (ent(2) !== 8'h5A) begin n_err++; $display("FAIL spi_write_bank2: got %h want 5a", ent(2)); end
    n_cmp++; if (spi_ovf !== 1'b0) begin n_err++; $display("FAIL spi_write_ovf: got %b want 0", spi_ovf); end
  endtask

  // Relies on bank[2] = 0x5A left by test_spi_write.
  task automatic test_core_read();
    bit got = 0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd2;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (core_gnt) got = 1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL core_read_gnt: got no grant want grant within 8"); end
    @(negedge clk);
    n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL core_read_gnt_width: got %b want 0", core_gnt); end
    n_cmp++; if (core_rvld !== 1'b1) begin n_err++; $display("FAIL core_read_rvld: got %b want 1", core_rvld); end
    n_cmp++; if (core_rdata !== 8'h5A) begin n_err++; $display("FAIL core_read_data: got %h want 5a", core_rdata); end
    core_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (core_rvld !== 1'b0) begin n_err++; $display("FAIL core_read_rvld_pulse: got %b want 0", core_rvld); end
    n_cmp++; if (core_rdata !== 8'h5A) begin n_err++; $display("FAIL core_read_hold: got %h want 5a", core_rdata); end
  endtask

  task automatic test_collision();
    apply_reset();
    spi_wvld = 1'b1; spi_addr = 3'd1; spi_wdata = 8'h11;
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd1; core_wdata = 8'h22;
    @(negedge clk);
    spi_wvld = 1'b0;
    n_cmp++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL collide_spi_first: got gnt %b want 0", core_gnt); end
    @(negedge clk);
    n_cmp++; if (ent(1) !== 8'h11) begin n_err++; $display("FAIL collide_spi_commit: got %h want 11", ent(1)); end
    n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL collide_core_gnt: got %b want 1", core_gnt); end
    @(negedge clk);
    core_req = 1'b0;
    n_cmp++; if (ent(1) !== 8'h22) begin n_err++; $display("FAIL collide_final: got %h want 22", ent(1)); end
  endtask

  task automatic test_ignore();
    bit saw_gnt = 0;
    apply_reset();
    spi_wvld = 1'b1; spi_addr = 3'd4; spi_wdata = 8'h44;
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'h99;
    @(negedge clk);
    spi_wvld = 1'b0; core_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (core_gnt) saw_gnt = 1;
    end
    n_cmp++; if (saw_gnt) begin n_err++; $display("FAIL ignore_gnt: got grant want none"); end
    n_cmp++; if (ent(5) !== 8'h00) begin n_err++; $display("FAIL ignore_bank5: got %h want 00", ent(5)); end
    n_cmp++; if (ent(4) !== 8'h44) begin n_err++; $display("FAIL ignore_bank4: got %h want 44", ent(4)); end
  endtask

  task automatic test_overflow();
    apply_reset();
    // One SPI grant so the core wins the next tie.
    spi_wvld = 1'b1; spi_addr = 3'd0; spi_wdata = 8'h01;
    @(negedge clk);
    spi_wvld = 1'b0;
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd6; core_wdata = 8'h60;
    spi_wvld = 1'b1; spi_addr = 3'd5; spi_wdata = 8'hA1;
    @(negedge clk);
    n_cmp++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL ovf_core_wins: got %b want 1", core_gnt); end
    spi_wdata = 8'hA2;
    @(negedge clk);
    spi_wvld = 1'b0; core_req = 1'b0;
    n_cmp++; if (spi_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", spi_ovf); end
    @(negedge clk);
    n_cmp++; if (ent(5) !== 8'hA1) begin n_err++; $display("FAIL ovf_first_kept: got %h want a1", ent(5)); end
    n_cmp++; if (ent(6) !== 8'h60) begin n_err++; $display("FAIL ovf_core_write: got %h want 60", ent(6)); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (spi_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", spi_ovf); end
    // Clear coinciding with a fresh overflow: set must win.
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd6; core_wdata = 8'h61;
    spi_wvld = 1'b1; spi_addr = 3'd5; spi_wdata = 8'hB1;
    @(negedge clk);
    spi_wdata = 8'hB2; ovf_clr = 1'b1;
    @(negedge clk);
    spi_wvld = 1'b0; core_req = 1'b0; ovf_clr = 1'b0;
    n_cmp++; if (spi_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", spi_ovf); end
    @(negedge clk);
    n_cmp++; if (ent(5) !== 8'hB1) begin n_err++; $display("FAIL ovf_second_kept: got %h want b1", ent(5)); end
  endtask

  task automatic test_forward();
    apply_reset();
    spi_wvld = 1'b1; spi_addr = 3'd3; spi_wdata = 8'h77;
    @(negedge clk);
    spi_wvld = 1'b0;
    n_cmp++; if (spi_rdata !== 8'h77) begin n_err++; $display("FAIL fwd_pending: got %h want 77", spi_rdata); end
    n_cmp++; if (ent(3) !== 8'h00) begin n_err++; $display("FAIL fwd_not_committed: got %h want 00", ent(3)); end
    @(negedge clk);
    n_cmp++; if (ent(3) !== 8'h77) begin n_err++; $display("FAIL fwd_committed: got %h want 77", ent(3)); end
    spi_addr = 3'd2;
    @(negedge clk);
    n_cmp++; if (spi_rdata !== 8'h00) begin n_err++; $display("FAIL fwd_other_addr: got %h want 00", spi_rdata); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      spi_wvld = 1'b1; spi_addr = 3'(k); spi_wdata = 8'h30 + 8'(k);
      @(negedge clk);
    end
    spi_wvld = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ent(k) !== 8'h30 + 8'(k)) begin
        n_err++; $display("FAIL b2b_bank%0d: got %h want %h", k, ent(k), 8'h30 + 8'(k));
      end
    end
    n_cmp++; if (spi_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", spi_ovf); end
  endtask

  task automatic test_latency();
    bit waiting = 0;
    bit seen = 0;
    int cyc = 0;
    int lat = 0;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      spi_wvld = 1'b1; spi_addr = 3'(k); spi_wdata = 8'(k);
      if (k == 2) begin
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd0; waiting = 1;
      end else if (seen) begin
        core_req = 1'b0;
      end
      @(negedge clk);
      if (waiting) begin
        cyc++;
        if (core_gnt) begin lat = cyc; waiting = 0; seen = 1; end
      end
    end
    spi_wvld = 1'b0; core_req = 1'b0;
    n_cmp++;
    if (!seen || lat > 2) begin
      n_err++; $display("FAIL core_latency: got seen=%0d lat=%0d want lat<=2", seen, lat);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    spi_wvld = 1'b1; spi_addr = 3'd6; spi_wdata = 8'h66;
    @(negedge clk);
    spi_wvld = 1'b0; nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ent(6) !== 8'h00) begin n_err++; $display("FAIL reset_mid_bank6: got %h want 00", ent(6)); end
    n_cmp++; if (spi_rdata !== 8'h00) begin n_err++; $display("FAIL reset_mid_pend: got %h want 00", spi_rdata); end
  endtask

  task automatic test_top_addr();
    bit got = 0;
    apply_reset();
    spi_wvld = 1'b1; spi_addr = 3'd7; spi_wdata = 8'hFF;
    @(negedge clk);
    spi_wvld = 1'b0;
    @(negedge clk);
`ifdef SPI_REG_ARB_RO_TOP_EN
    n_cmp++; if (ent(7) !== 8'h00) begin n_err++; $display("FAIL ro_top_spi: got %h want 00", ent(7)); end
    n_cmp++; if (spi_ovf !== 1'b0) begin n_err++; $display("FAIL ro_top_ovf: got %b want 0", spi_ovf); end
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd7; core_wdata = 8'hFF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (core_gnt) got = 1;
    end
    @(negedge clk);
    core_req = 1'b0;
    n_cmp++; if (ent(7) !== 8'hFF) begin n_err++; $display("FAIL ro_top_core: got %h want ff", ent(7)); end
`else
    n_cmp++; if (ent(7) !== 8'hFF) begin n_err++; $display("FAIL top_spi_write: got %h want ff", ent(7)); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_spi_write();
    test_core_read();
    test_collision();
    test_ignore();
    test_overflow();
    test_forward();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_top_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
